// File: rtl/instruction_fetch.sv
// Instruction fetch/issue stage: PC walker over a synchronous-read imem, one-entry skid buffer
// for downstream stall, hold-and-redirect on class-11 branches. Define FETCH_HALT_EN to build halt.
module instruction_fetch #(
  parameter int          ADDR_W   = 8,
  parameter logic [23:0] NOP_CODE = 24'h0003F0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [23:0]       imem_data,
  output logic [23:0]       code,
  output logic              code_valid,
  input  logic              br_valid,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT_BR
`ifdef FETCH_HALT_EN
    , S_HALT
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              rd_pending_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              skid_valid_q;
  logic [23:0]       skid_data_q;
  logic [ADDR_W-1:0] skid_addr_q;
  logic [23:0]       code_q;
  logic              code_valid_q;
  logic [ADDR_W-1:0] br_pc_q;

  logic              issue;
  logic              present;
  logic              is_branch;
  logic [23:0]       word;
  logic [ADDR_W-1:0] word_addr;

  // A read may issue while the skid still holds a word: the skid drains in that same cycle,
  // so the returning data never meets an occupied skid.
  assign issue = !rst && (state_q == S_FETCH) && !stall;

  // The skid word is older than anything returning from memory, so it is presented first.
  assign word      = skid_valid_q ? skid_data_q : imem_data;
  assign word_addr = skid_valid_q ? skid_addr_q : rd_addr_q;
  assign present   = (skid_valid_q || rd_pending_q) && !stall;
  assign is_branch = present && (word[23:22] == 2'b11);

`ifdef FETCH_HALT_EN
  logic is_halt;
  logic halted_q;

  assign is_halt = is_branch && (word[14:12] == 3'b111);
  assign halted  = halted_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else if (is_halt) begin
      halted_q <= 1'b1;
    end
  end
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: defaults first, so every path assigns state_d/pc_d and no latch is inferred.
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_FETCH: begin
        // The PC holds on a branch; the read issued alongside it is discarded on return.
        if (is_branch) begin
          state_d = S_WAIT_BR;
`ifdef FETCH_HALT_EN
          if (is_halt) state_d = S_HALT;
`endif
        end else if (issue) begin
          pc_d = pc_q + ADDR_W'(1);
        end
      end
      S_WAIT_BR: begin
        if (br_valid) begin
          state_d = S_FETCH;
          pc_d    = br_taken ? br_target : br_pc_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= '0;
      rd_pending_q <= 1'b0;
      rd_addr_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= NOP_CODE;
      skid_addr_q  <= '0;
      code_q       <= NOP_CODE;
      code_valid_q <= 1'b0;
      br_pc_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values together.
      pc_q         <= pc_d;
      rd_pending_q <= issue && !is_branch;
      rd_addr_q    <= pc_q;
      if (!stall) begin
        skid_valid_q <= 1'b0;
        code_q       <= present ? word : NOP_CODE;
        code_valid_q <= present;
        if (is_branch) br_pc_q <= word_addr;
      end else if (rd_pending_q) begin
        skid_valid_q <= 1'b1;
        skid_data_q  <= imem_data;
        skid_addr_q  <= rd_addr_q;
      end
    end
  end

  assign imem_en    = issue;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign code       = code_q;
  assign code_valid = code_valid_q;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch and issue stage for the 24-bit processor datapath. Walks a program counter over a synchronous-read instruction memory and presents one registered 24-bit instruction word per cycle to the control unit's `code` input. Holds issue while a class-11 (compare/branch) instruction resolves, then redirects on the resolution result. Supports a downstream stall through a one-entry skid buffer, so no fetched word is ever lost or duplicated.

## Interface
- `ADDR_W`, 8: instruction memory address width; PC width.
- `NOP_CODE`, 24'h0003F0: bubble word (class 00, ALU field [9:4] = 6'b111111).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall`  in  1  downstream hold; `code` and `code_valid` must not change while high.
- `imem_en`  out  1  read strobe to instruction memory.
- `imem_addr`  out  ADDR_W  read address.
- `imem_data`  in  24  read data, valid the cycle after `imem_en`.
- `code`  out  24  instruction word to control unit.
- `code_valid`  out  1  `code` is a real instruction (0 = bubble).
- `br_valid`  in  1  branch resolution strobe, one cycle.
- `br_taken`  in  1  branch taken, qualified by `br_valid`.
- `br_target`  in  ADDR_W  taken target, qualified by `br_valid`.
- `pc`  out  ADDR_W  address of the next read to issue.
- `halted`  out  1  halt instruction issued; fetch stopped.

## Operation
- Reset values: `pc`=0, `imem_en`=0, `imem_addr`=0, `code`=NOP_CODE, `code_valid`=0, `halted`=0, skid empty, state FETCH.
- FETCH: each cycle with `stall`=0 and skid empty, drive `imem_en`=1 and `imem_addr`=`pc`, then `pc`<=`pc`+1. The PC wraps from 2^ADDR_W-1 to 0.
- Returning data (read issued in the previous cycle) with `stall`=0 loads `code`<=`imem_data` and `code_valid`<=1.
- With `stall`=1, returning data goes to the skid buffer, and no new read is issued. After `stall` falls, the skid word is presented first, the skid empties, and issue resumes in the same cycle.
- With no valid word to present and `stall`=0, `code`<=NOP_CODE and `code_valid`<=0.
- Branch detect: a word with [23:22]=2'b11 that is loaded into `code` enters WAIT_BR, and its address is saved as `br_pc`.
  - Any read issued in that cycle is discarded when it returns.
  - `pc` is not advanced further.
- WAIT_BR: no reads are issued, and bubbles are presented.
  - On `br_valid`: `pc`<=`br_taken` ? `br_target` : `br_pc`+1, then go to FETCH.
  - `br_valid` is accepted even while `stall`=1; issue waits for `stall`=0.
- `br_valid` outside WAIT_BR is ignored.
- HALT (when enabled): the class-11 word with [14:12]=3'b111 is presented normally. Then `halted`<=1 and state goes to HALT.
  - No further reads; bubbles forever; in-flight data discarded.
  - Only `rst` exits HALT.
- `rst` asserted mid-operation: all state returns to reset values immediately. Skid contents and any in-flight read are dropped.

## Timing
- Fetch latency: address issued in cycle t; `code` is visible in cycle t+2.
- Steady throughput: one word per cycle.
- Branch penalty: the branch word appears at cycle b, and `br_valid` arrives at cycle r ≥ b+1.
  - First new read is issued in cycle r+1.
  - First new `code` appears at r+3.
  - Bubbles are presented from b+1 to r+2.
- Stall: `code` is frozen from the first cycle `stall` is sampled high. The word after it appears one cycle after `stall` is sampled low; that word comes from the skid buffer if the skid is occupied.
- Skid occupancy never exceeds 1.

## Configuration
- `FETCH_HALT_EN` defined: class 11 with [14:12]=3'b111 is a halt, handled as in HALT above, with `halted` driven.
- `FETCH_HALT_EN` undefined:
  - Subop 3'b111 is treated as an ordinary branch, entering WAIT_BR.
  - `halted` is tied to 0, and the HALT state is not built.

## Test plan
- Sequential fetch:
  - Stimulus: memory words 0..3 = 24'h000130, 24'h000090, 24'h400000, 24'h401000.
  - Required: `code` shows these words in cycles 2..5 after reset release, with `code_valid`=1 and `pc` incrementing 0→4.
- Taken branch:
  - Stimulus: word 2 = 24'hC00000, and `br_valid`=1, `br_taken`=1, `br_target`=8'h10 are asserted 2 cycles after the branch appears.
  - Required: bubbles of NOP_CODE with `code_valid`=0, then word 0x10; word 3 is never presented.
- Not-taken branch:
  - Stimulus: same program, `br_taken`=0.
  - Required: next presented word is word 3; `pc` resumes at 4.
- Stall with skid:
  - Stimulus: assert `stall` for 3 cycles while word 5 is in flight.
  - Required:
    - `code` is held on word 4.
    - After release, words 5 and 6 follow on consecutive cycles, with no duplicate and no drop.
    - `imem_en`=0 throughout the stall.
- Wrap and reset:
  - Stimulus: start at PC 8'hFF.
  - Required: the next read address is 8'h00.
  - Stimulus: assert `rst` mid-WAIT_BR.
  - Required: `pc`=0, `code`=NOP_CODE, `code_valid`=0 asynchronously.
- Halt (FETCH_HALT_EN):
  - Stimulus: word 1 = 24'hC07000.
  - Required: it is presented once, then `halted`=1 and `imem_en` stays 0 for 20 cycles.
  - Without the macro, the same word waits for `br_valid`.
